kudu_irq_arbiter: RTL and testbench

Interrupt scheduler for the kudu core's trap path.
- Registers raw interrupt lines and presents them as mip.
- Masks pending interrupts with mie, mstatus.MIE and debug mode.
- Picks one winner by fixed priority and holds a registered request/cause to the controller until it is acknowledged.
- Tracks NMI mode until mret.
- Sits between the core interrupt pins and the CSR/controller trap-entry logic.

---
 rtl/kudu_irq_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_kudu_irq_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/kudu_irq_arbiter.sv
// Interrupt scheduler for the kudu trap path: registers raw lines as mip, masks them and
// holds one fixed-priority request/cause until acked. Optional macro: KUDU_IRQ_SYNC_EN.
module kudu_irq_arbiter #(
    parameter bit NmiEdge  = 1'b1,
    parameter int FastIrqW = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        irq_software_i,
    input  logic        irq_timer_i,
    input  logic        irq_external_i,
    input  logic [14:0] irq_fast_i,
    input  logic        irq_nm_i,
    input  logic [17:0] mie_i,
    input  logic        mstatus_mie_i,
    input  logic        debug_mode_i,
    input  logic        irq_ack_i,
    input  logic        mret_i,
    output logic [17:0] mip_o,
    output logic        irq_req_o,
    output logic [5:0]  irq_cause_o,
    output logic        irq_nmi_o,
    output logic        nmi_mode_o
);

    typedef enum logic [1:0] {IDLE, REQ, NMI_ACT} state_e;

    localparam logic [5:0] CauseNmi = 6'h3F;
    localparam logic [5:0] CauseExt = 6'h2B;
    localparam logic [5:0] CauseSw  = 6'h23;
    localparam logic [5:0] CauseTmr = 6'h27;

    generate
        if (FastIrqW != 15) begin : g_bad_fast_width
            $error("kudu_irq_arbiter: FastIrqW must be 15");
        end
    endgenerate

    // irq_in layout: {nm, sw, timer, ext, fast[14:0]}
    logic [18:0] irq_in;

`ifdef KUDU_IRQ_SYNC_EN
    logic [18:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {irq_nm_i, irq_software_i, irq_timer_i, irq_external_i, irq_fast_i};
            sync2_q <= sync1_q;
        end
    end

    assign irq_in = sync2_q;
`else
    assign irq_in = {irq_nm_i, irq_software_i, irq_timer_i, irq_external_i, irq_fast_i};
`endif

    state_e      state_q, state_d;
    logic [17:0] mip_q, mip_d;
    logic        nm_prev_q, nm_prev_d;
    logic        nmi_pend_q, nmi_pend_d;
    logic        irq_req_q, irq_req_d;
    logic [5:0]  irq_cause_q, irq_cause_d;
    logic        irq_nmi_q, irq_nmi_d;
    logic        nmi_mode_q, nmi_mode_d;

    logic [17:0] elig;
    logic        nmi_elig;
    logic        held_elig;
    logic [5:0]  win_cause;
    logic        nmi_set, nmi_clr;

    always_comb begin
        mip_d     = irq_in[17:0];
        nm_prev_d = irq_in[18];
        nmi_set   = NmiEdge ? (irq_in[18] & ~nm_prev_q) : irq_in[18];
        nmi_clr   = (state_q == REQ) & irq_ack_i & irq_nmi_q;
        if (NmiEdge) begin
            nmi_pend_d = nmi_set | (nmi_pend_q & ~nmi_clr);
        end else begin
            nmi_pend_d = nmi_set;
        end
    end

    always_comb begin
        elig     = mip_q & mie_i & {18{mstatus_mie_i & ~nmi_mode_q & ~debug_mode_i}};
        nmi_elig = nmi_pend_q & ~nmi_mode_q & ~debug_mode_i;
        // Fast cause low nibble equals the fast index, so it addresses elig directly.
        case (irq_cause_q)
            CauseExt: held_elig = elig[15];
            CauseSw:  held_elig = elig[17];
            CauseTmr: held_elig = elig[16];
            default:  held_elig = elig[{1'b0, irq_cause_q[3:0]}];
        endcase
    end

    always_comb begin
        win_cause = 6'h00;
        for (int i = 14; i >= 0; i--) begin
            if (elig[i]) win_cause = {1'b1, 5'(16 + i)};
        end
        if (elig[16]) win_cause = CauseTmr;
        if (elig[17]) win_cause = CauseSw;
        if (elig[15]) win_cause = CauseExt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (nmi_elig || (|elig)) state_d = REQ;
            end
            REQ: begin
                if (irq_ack_i) begin
                    state_d = irq_nmi_q ? NMI_ACT : IDLE;
                end else if (irq_nmi_q) begin
                    if (debug_mode_i) state_d = IDLE;
                end else if (!nmi_elig && !held_elig) begin
                    state_d = IDLE;
                end
            end
            NMI_ACT: begin
                if (mret_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_req_d   = irq_req_q;
        irq_cause_d = irq_cause_q;
        irq_nmi_d   = irq_nmi_q;
        nmi_mode_d  = nmi_mode_q;
        case (state_q)
            IDLE: begin
                if (nmi_elig) begin
                    irq_req_d   = 1'b1;
                    irq_cause_d = CauseNmi;
                    irq_nmi_d   = 1'b1;
                end else if (|elig) begin
                    irq_req_d   = 1'b1;
                    irq_cause_d = win_cause;
                    irq_nmi_d   = 1'b0;
                end
            end
            REQ: begin
                if (irq_ack_i) begin
                    irq_req_d = 1'b0;
                    irq_nmi_d = 1'b0;
                    if (irq_nmi_q) nmi_mode_d = 1'b1;
                end else if (irq_nmi_q) begin
                    if (debug_mode_i) begin
                        irq_req_d = 1'b0;
                        irq_nmi_d = 1'b0;
                    end
                end else if (nmi_elig) begin
                    irq_cause_d = CauseNmi;
                    irq_nmi_d   = 1'b1;
                end else if (!held_elig) begin
                    irq_req_d = 1'b0;
                end
            end
            NMI_ACT: begin
                irq_req_d = 1'b0;
                irq_nmi_d = 1'b0;
                if (mret_i) nmi_mode_d = 1'b0;
            end
            default: begin
                irq_req_d = 1'b0;
                irq_nmi_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mip_q       <= '0;
            nm_prev_q   <= 1'b0;
            nmi_pend_q  <= 1'b0;
            irq_req_q   <= 1'b0;
            irq_cause_q <= '0;
            irq_nmi_q   <= 1'b0;
            nmi_mode_q  <= 1'b0;
        end else begin
            mip_q       <= mip_d;
            nm_prev_q   <= nm_prev_d;
            nmi_pend_q  <= nmi_pend_d;
            irq_req_q   <= irq_req_d;
            irq_cause_q <= irq_cause_d;
            irq_nmi_q   <= irq_nmi_d;
            nmi_mode_q  <= nmi_mode_d;
        end
    end

    assign mip_o       = mip_q;
    assign irq_req_o   = irq_req_q;
    assign irq_cause_o = irq_cause_q;
    assign irq_nmi_o   = irq_nmi_q;
    assign nmi_mode_o  = nmi_mode_q;

endmodule

// File: tb/tb_kudu_irq_arbiter.sv
// Self-checking bench for kudu_irq_arbiter: expected {nmi, cause} requests are queued by the
// stimulus thread and popped by a monitor whenever a new request appears on the outputs.
module tb_kudu_irq_arbiter;

   logic        clk;
   logic        rstN;
   logic        irqSoftware;
   logic        irqTimer;
   logic        irqExternal;
   logic [14:0] irqFast;
   logic        irqNm;
   logic [17:0] mie;
   logic        mstatusMie;
   logic        debugMode;
   logic        irqAck;
   logic        mret;
   logic [17:0] mip;
   logic        irqReq;
   logic [5:0]  irqCause;
   logic        irqNmi;
   logic        nmiMode;

   int checks = 0;
   int failures = 0;
   logic [6:0] expQ[$];

   kudu_irq_arbiter dut (
      .clk_i          (clk),
      .rst_ni         (rstN),
      .irq_software_i (irqSoftware),
      .irq_timer_i    (irqTimer),
      .irq_external_i (irqExternal),
      .irq_fast_i     (irqFast),
      .irq_nm_i       (irqNm),
      .mie_i          (mie),
      .mstatus_mie_i  (mstatusMie),
      .debug_mode_i   (debugMode),
      .irq_ack_i      (irqAck),
      .mret_i         (mret),
      .mip_o          (mip),
      .irq_req_o      (irqReq),
      .irq_cause_o    (irqCause),
      .irq_nmi_o      (irqNmi),
      .nmi_mode_o     (nmiMode)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: bumps the counters and reports a mismatch
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Advance one clock and settle just after the rising edge
   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Watches for a new request (rise of irqReq or change of cause) and checks it against the queue
   task automatic monitorRequests();
      logic       prevReq;
      logic [6:0] prevTag;
      logic [6:0] expTag;
      prevReq = 1'b0;
      prevTag = '0;
      forever begin
         @(negedge clk);
         if (irqReq && (!prevReq || {irqNmi, irqCause} != prevTag)) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_req: got nmi=%0b cause=0x%0h, expected no request at %0t",
                        irqNmi, irqCause, $time);
            end else begin
               expTag = expQ.pop_front();
               checkOutput("req_cause", {25'd0, irqNmi, irqCause}, {25'd0, expTag});
            end
         end
         prevReq = irqReq;
         prevTag = {irqNmi, irqCause};
      end
   endtask

   initial begin
      rstN        = 1'b0;
      irqSoftware = 1'b0;
      irqTimer    = 1'b0;
      irqExternal = 1'b0;
      irqFast     = '0;
      irqNm       = 1'b0;
      mie         = '0;
      mstatusMie  = 1'b0;
      debugMode   = 1'b0;
      irqAck      = 1'b0;
      mret        = 1'b0;

      fork
         monitorRequests();
      join_none

      applyStimulus(2);
      checkOutput("reset_mip", {14'd0, mip}, 32'h0);
      checkOutput("reset_outs", {27'd0, irqReq, irqNmi, nmiMode, 2'b00}, 32'h0);
      checkOutput("reset_cause", {26'd0, irqCause}, 32'h0);

      // Timer only: mip after one edge, request after two, drop after ack
      irqTimer   = 1'b1;
      mie        = 18'h10000;
      mstatusMie = 1'b1;
      expQ.push_back({1'b0, 6'h27});
      rstN = 1'b1;
      applyStimulus(1);
      checkOutput("timer_mip", {14'd0, mip}, 32'h10000);
      checkOutput("timer_req_lat1", {31'd0, irqReq}, 32'h0);
      applyStimulus(1);
      checkOutput("timer_req_lat2", {31'd0, irqReq}, 32'h1);
      irqAck   = 1'b1;
      irqTimer = 1'b0;
      applyStimulus(1);
      irqAck = 1'b0;
      checkOutput("timer_ack_drop", {31'd0, irqReq}, 32'h0);
      applyStimulus(2);
      checkOutput("timer_idle", {31'd0, irqReq}, 32'h0);

      // Ext beats sw and fast[3]; after ack sw wins
      mie         = 18'h3FFFF;
      irqExternal = 1'b1;
      irqSoftware = 1'b1;
      irqFast     = 15'h0008;
      expQ.push_back({1'b0, 6'h2B});
      applyStimulus(2);
      checkOutput("ext_req", {31'd0, irqReq}, 32'h1);
      expQ.push_back({1'b0, 6'h23});
      irqAck      = 1'b1;
      irqExternal = 1'b0;
      applyStimulus(1);
      irqAck = 1'b0;
      checkOutput("ext_ack_drop", {31'd0, irqReq}, 32'h0);
      applyStimulus(1);
      checkOutput("sw_cause", {26'd0, irqCause}, 32'h23);

      // NMI preempts the held sw request
      irqFast = '0;
      irqNm   = 1'b1;
      expQ.push_back({1'b1, 6'h3F});
      applyStimulus(1);
      irqNm = 1'b0;
      checkOutput("preempt_hold", {26'd0, irqCause}, 32'h23);
      applyStimulus(1);
      checkOutput("preempt_nmi", {31'd0, irqNmi}, 32'h1);
      checkOutput("preempt_cause", {26'd0, irqCause}, 32'h3F);
      irqAck = 1'b1;
      applyStimulus(1);
      irqAck = 1'b0;
      checkOutput("nmi_mode_set", {30'd0, nmiMode, irqReq}, 32'h2);

      // Second NMI is latched but silent until mret
      irqNm = 1'b1;
      applyStimulus(1);
      irqNm = 1'b0;
      applyStimulus(3);
      checkOutput("nmi_act_noreq", {31'd0, irqReq}, 32'h0);
      expQ.push_back({1'b1, 6'h3F});
      mret = 1'b1;
      applyStimulus(1);
      mret = 1'b0;
      checkOutput("mret_mode_clr", {31'd0, nmiMode}, 32'h0);
      applyStimulus(1);
      checkOutput("nmi2_req", {30'd0, irqReq, irqNmi}, 32'h3);
      irqAck = 1'b1;
      applyStimulus(1);
      irqAck = 1'b0;
      checkOutput("nmi2_mode", {31'd0, nmiMode}, 32'h1);
      expQ.push_back({1'b0, 6'h23});
      mret = 1'b1;
      applyStimulus(1);
      mret = 1'b0;
      applyStimulus(1);
      checkOutput("sw_after_mret", {31'd0, irqReq}, 32'h1);
      irqAck      = 1'b1;
      irqSoftware = 1'b0;
      applyStimulus(1);
      irqAck = 1'b0;
      applyStimulus(2);
      checkOutput("sw_cleared", {31'd0, irqReq}, 32'h0);

      // Withdrawal: timer drops while held, no ack
      irqTimer = 1'b1;
      expQ.push_back({1'b0, 6'h27});
      applyStimulus(2);
      checkOutput("wd_req", {31'd0, irqReq}, 32'h1);
      irqTimer = 1'b0;
      applyStimulus(1);
      checkOutput("wd_still_held", {31'd0, irqReq}, 32'h1);
      applyStimulus(1);
      checkOutput("wd_dropped", {31'd0, irqReq}, 32'h0);

      // Debug masks both NMI and fast[14]
      debugMode = 1'b1;
      irqFast   = 15'h4000;
      irqNm     = 1'b1;
      applyStimulus(1);
      irqNm = 1'b0;
      applyStimulus(4);
      checkOutput("debug_noreq", {31'd0, irqReq}, 32'h0);
      expQ.push_back({1'b1, 6'h3F});
      debugMode = 1'b0;
      applyStimulus(1);
      checkOutput("debug_exit_nmi", {30'd0, irqReq, irqNmi}, 32'h3);
      checkOutput("debug_exit_cause", {26'd0, irqCause}, 32'h3F);
      applyStimulus(1);

      // Asynchronous reset while the NMI request is held
      rstN = 1'b0;
      #1;
      checkOutput("async_rst_outs", {27'd0, irqReq, irqNmi, nmiMode, 2'b00}, 32'h0);
      checkOutput("async_rst_mip", {14'd0, mip}, 32'h0);
      irqFast = '0;
      applyStimulus(2);
      rstN = 1'b1;
      applyStimulus(4);
      checkOutput("post_rst_noreq", {31'd0, irqReq}, 32'h0);
      checkOutput("queue_empty", expQ.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
